// File: rtl/mem_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bus_initiator: valid/ready request/response front end for a single-   |
// | port synchronous word memory; owns the tristate data driver.              |
// | Optional feature macro: MEM_BUS_BOUNDS_CHECK_EN (reject index >= DEPTH).  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_bus_initiator #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int WORD_W    = 32,
  parameter int DEPTH     = 256,
  parameter int BYTE_ADDR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  output logic              rw
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_req_ready;
  logic              w_resp_valid;
  logic              w_accept;
  logic              w_err;
  logic [ADDR_W-1:0] w_conv_addr;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rw;
  logic              r_err;

  assign w_conv_addr = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;

`ifdef MEM_BUS_BOUNDS_CHECK_EN
  assign w_err = (w_conv_addr >= ADDR_W'(DEPTH));
`else
  logic w_unused_depth;
  assign w_unused_depth = (DEPTH > 0);
  assign w_err          = 1'b0;
`endif

  generate
    if (WORD_W < DATA_W) begin : g_upper_unused
      logic w_unused_upper;
      assign w_unused_upper = ^data[DATA_W-1:WORD_W];
    end
  endgenerate

  assign w_accept = req_valid && w_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)       w_next_state = S_RESP;
          else if (req_we) w_next_state = S_WR;
          else             w_next_state = S_RD_ADDR;
        end
      end
      S_WR:      w_next_state = S_RESP;
      S_RD_ADDR: w_next_state = S_RD_DATA;
      S_RD_DATA: w_next_state = S_RESP;
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (resp_ready) w_next_state = S_IDLE;
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  // rw doubles as the data output enable, so it comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rw <= (w_next_state == S_WR);
      if (w_accept) begin
        r_err   <= w_err;
        r_rdata <= '0;
        if (!w_err) begin
          r_addr  <= w_conv_addr;
          r_wdata <= req_wdata;
        end
      end
      if (r_state == S_RD_DATA) begin
        r_rdata <= DATA_W'(data[WORD_W-1:0]);
      end
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = w_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign addr       = r_addr;
  assign rw         = r_rw;
  assign data       = r_rw ? r_wdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_bus_initiator: directed bench with a word memory on the bus and a  |
// | latency-based reference model of the request/response behaviour.         |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mem_bus_initiator;

`ifdef MEM_BUS_BOUNDS_CHECK_EN
  localparam bit C_BC = 1'b1;
`else
  localparam bit C_BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] addr;
  wire  [63:0] data;
  logic        rw;

  mem_bus_initiator dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .addr       (addr),
    .data       (data),
    .rw         (rw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus memory: upper read bits carry junk so zero-extension is exercised.
  logic [31:0] mem [0:1023];
  logic [63:0] mem_q = 64'h0;
  always @(posedge clk) begin
    if (rw) mem[addr[9:0]] <= data[31:0];
    else    mem_q <= {32'hA5A5_A5A5, mem[addr[9:0]]};
  end
  assign data = rw ? 64'bz : mem_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: busy flag plus accept cycle and fixed latencies.
  logic [31:0] ref_mem [0:1023];
  bit          chk_en = 1'b0;
  bit          m_busy = 1'b0;
  int          m_acc, m_lat;
  bit          m_we, m_err;
  logic [63:0] m_idx, m_wdata, m_rdata;
  logic [63:0] m_addr = 64'h0;
  bit          exp_rw, exp_rv;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC000_0000 + 32'(i);
      ref_mem[i] = 32'hC000_0000 + 32'(i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rw = m_busy && m_we && !m_err && (cyc == m_acc + 1);
      exp_rv = m_busy && (cyc >= m_acc + m_lat);
      chk("req_ready", req_ready, !m_busy);
      chk("rw", rw, exp_rw);
      chk("addr", addr, m_addr);
      chk("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", resp_err, m_err);
      end
      if (exp_rw) chk("wr_data", data, m_wdata);
      if (!rw)    chk("bus_contention", data, mem_q);

      if (exp_rw) ref_mem[m_idx[9:0]] = m_wdata[31:0];
      if (reset) begin
        m_busy = 1'b0;
        m_addr = 64'h0;
      end else if (m_busy) begin
        if (exp_rv && resp_ready) m_busy = 1'b0;
      end else if (req_valid) begin
        m_busy  = 1'b1;
        m_acc   = cyc;
        m_we    = req_we;
        m_idx   = req_addr >> 2;
        m_err   = C_BC && (m_idx >= 64'd256);
        m_lat   = m_err ? 1 : (m_we ? 2 : 3);
        m_wdata = req_wdata;
        m_rdata = (m_we || m_err) ? 64'h0 : {32'h0, ref_mem[m_idx[9:0]]};
        if (!m_err) m_addr = m_idx;
      end
    end
  end

  task automatic start_req(input logic we, input logic [63:0] a, input logic [63:0] wd,
                           output int t0);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 64'(n < 20), 64'd1);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd;
  endtask

  task automatic finish_resp(input int t0, input int stall, output int lat,
                             output logic [63:0] rd, output logic er, output int hs);
    int n;
    resp_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("resp_timeout", 64'(n < 20), 64'd1);
    lat = cyc - t0;
    rd  = resp_rdata;
    er  = resp_err;
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1'b1);
      chk("stall_rdata", resp_rdata, rd);
      chk("stall_ready", req_ready, 1'b0);
    end
    if (stall > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
    end
    hs = cyc;
  endtask

  int          t0, t1, lat, hs, prev_hs;
  logic [63:0] rd;
  logic        er;
  logic [31:0] pat;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_addr", addr, 64'h0);

    // Write 0x10 then read it back.
    start_req(1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, t0);
    @(negedge clk);
    chk("w1_rw", rw, 1'b1);
    chk("w1_addr", addr, 64'h4);
    chk("w1_data", data, 64'h0000_0000_DEAD_BEEF);
    finish_resp(t0, 0, lat, rd, er, hs);
    chk("w1_lat", 64'(lat), 64'd2);
    chk("w1_rdata", rd, 64'h0);

    start_req(1'b0, 64'h10, 64'h0, t0);
    finish_resp(t0, 0, lat, rd, er, hs);
    chk("r1_lat", 64'(lat), 64'd3);
    chk("r1_rdata", rd, 64'h0000_0000_DEAD_BEEF);

    // Stalled response, then an immediate next request.
    start_req(1'b0, 64'h10, 64'h0, t0);
    finish_resp(t0, 5, lat, rd, er, hs);
    chk("stall_lat", 64'(lat), 64'd3);
    chk("stall_rd", rd, 64'h0000_0000_DEAD_BEEF);
    start_req(1'b1, 64'h20, 64'h1111_2222, t0);
    chk("post_hs_accept", 64'(t0 - hs), 64'd1);
    finish_resp(t0, 0, lat, rd, er, hs);

    // Reset during RD_DATA.
    start_req(1'b0, 64'h10, 64'h0, t0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rrd_ready", req_ready, 1'b1);
    chk("rrd_rw", rw, 1'b0);
    chk("rrd_addr", addr, 64'h0);
    chk("rrd_valid", resp_valid, 1'b0);
    chk("rrd_rdata", resp_rdata, 64'h0);
    chk("rrd_err", resp_err, 1'b0);
    repeat (4) begin @(negedge clk); chk("rrd_no_resp", resp_valid, 1'b0); end

    // Reset on the accept cycle of a write to 0x20.
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h3333_4444;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rwa_ready", req_ready, 1'b1);
    chk("rwa_rw", rw, 1'b0);
    chk("rwa_valid", resp_valid, 1'b0);
    chk("rwa_addr", addr, 64'h0);
    repeat (3) begin @(negedge clk); chk("rwa_no_wr", rw, 1'b0); end
    start_req(1'b0, 64'h20, 64'h0, t0);
    finish_resp(t0, 0, lat, rd, er, hs);
    chk("rwa_readback", rd, 64'h0000_0000_1111_2222);

    // Out-of-range word index 256.
    start_req(1'b0, 64'h400, 64'h0, t0);
    finish_resp(t0, 0, lat, rd, er, hs);
    chk("oob_lat", 64'(lat), C_BC ? 64'd1 : 64'd3);
    chk("oob_err", 64'(er), C_BC ? 64'd1 : 64'd0);
    chk("oob_rdata", rd, C_BC ? 64'h0 : 64'h0000_0000_C000_0100);
    chk("oob_addr", addr, C_BC ? 64'h8 : 64'h100);

    // Alternating write/read stream over 16 words.
    for (int i = 0; i < 16; i++) begin
      pat = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      prev_hs = hs;
      start_req(1'b1, 64'(i * 4), {32'hFFFF_0000 | 32'(i), pat}, t0);
      chk("wr_gap", 64'(t0 - prev_hs), 64'd1);
      finish_resp(t0, 0, lat, rd, er, hs);
      chk("wr_lat", 64'(lat), 64'd2);
      chk("wr_rdata", rd, 64'h0);
      start_req(1'b0, 64'(i * 4), 64'h0, t1);
      chk("wr_period", 64'(t1 - t0), 64'd3);
      finish_resp(t1, 0, lat, rd, er, hs);
      chk("rd_lat", 64'(lat), 64'd3);
      chk("rd_data", rd, {32'h0, pat});
      chk("rd_period", 64'(hs + 1 - t1), 64'd4);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
